// File: rtl/score_pkg.sv
// Shared types and constants for the score sequencer slice.
// Level-related constants are only consumed when SCORE_LEVEL_EN is defined.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    CONV,
    WAIT_FRAME
  } state_e;

  localparam int SCORE_W_DEF     = 10;
  localparam int SCORE_MAX_DEF   = 999;
  localparam int LEVEL_W_DEF     = 4;
  localparam int LINES_PER_LEVEL = 10;
  localparam int LEVEL_CAP       = 9;
  localparam int BCD_DIGITS      = 3;

  // Base points per line-clear event; out-of-range counts score nothing.
  function automatic logic [3:0] base_points(input logic [2:0] lines);
    case (lines)
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      3'd4:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] row_count(input logic [2:0] lines);
    return (lines >= 3'd1 && lines <= 3'd4) ? lines : 3'd0;
  endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// Event-producer / digit-consumer bundle for score_sequencer.
// master = game logic + renderer side, slave = score_sequencer.
interface score_sequencer_if
  import score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF
);

  logic               clear_valid;
  logic               clear_ready;
  logic [2:0]         lines_cleared;
  logic               frame_start;
  logic [SCORE_W-1:0] score;
  logic [3:0]         digit_hund;
  logic [3:0]         digit_tens;
  logic [3:0]         digit_ones;
  logic               digits_upd;
  logic [LEVEL_W-1:0] level;

  modport master (
    output clear_valid, lines_cleared, frame_start,
    input  clear_ready, score, digit_hund, digit_tens, digit_ones, digits_upd, level
  );

  modport slave (
    input  clear_valid, lines_cleared, frame_start,
    output clear_ready, score, digit_hund, digit_tens, digit_ones, digits_upd, level
  );

endinterface

// File: rtl/score_sequencer_bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, BIN_W steps per conversion.
// done is high during the final step; bcd holds the result from the following cycle on.
module bin2bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    bin_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      bin_reg  <= bin;
      bcd_reg  <= '0;
      cnt_reg  <= CNT_W'(BIN_W);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      bcd_reg <= {bcd_adj[4*DIGITS-2:0], bin_reg[BIN_W-1]};
      bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == CNT_W'(1));
  assign bcd  = bcd_reg;

endmodule

// File: rtl/score_sequencer.sv
// Saturating score keeper with frame-synchronous BCD digit commit.
// Optional SCORE_LEVEL_EN adds a lines/level counter that multiplies points.
module score_sequencer
  import score_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int SCORE_MAX = SCORE_MAX_DEF,
    parameter int LEVEL_W   = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_reset,
    score_sequencer_if.slave   bus
);

  localparam int SUM_W = SCORE_W + 1;
  localparam int BCD_W = 4 * BCD_DIGITS;

  logic               clear_all;
  state_e             state_reg, state_next;
  logic [2:0]         lines_reg;
  logic [SCORE_W-1:0] score_reg;
  logic [BCD_W-1:0]   digits_reg;
  logic               upd_reg;

  logic               conv_start, conv_busy, conv_done, commit;
  logic [BCD_W-1:0]   conv_bcd;
  logic [3:0]         base;
  logic [SUM_W-1:0]   pts, sum;
  logic [SCORE_W-1:0] add_score;

  assign clear_all = rst || game_reset;

`ifdef SCORE_LEVEL_EN
  localparam int PROD_W = 4 + LEVEL_W;

  logic [LEVEL_W-1:0] level_reg;
  logic [3:0]         lines_in_level_reg, lines_sum;
  logic [PROD_W-1:0]  prod;

  assign lines_sum = lines_in_level_reg + {1'b0, row_count(lines_reg)};

  // Level advances on the event that crosses the threshold; points use the pre-event level.
  always_ff @(posedge clk) begin
    if (clear_all) begin
      level_reg          <= '0;
      lines_in_level_reg <= '0;
    end else if (state_reg == ADD && level_reg < LEVEL_W'(LEVEL_CAP)) begin
      if (lines_sum >= 4'(LINES_PER_LEVEL)) begin
        level_reg          <= level_reg + LEVEL_W'(1);
        lines_in_level_reg <= lines_sum - 4'(LINES_PER_LEVEL);
      end else begin
        lines_in_level_reg <= lines_sum;
      end
    end
  end

  assign bus.level = level_reg;
`else
  assign bus.level = LEVEL_W'(0);
`endif

  always_comb begin
    base = base_points(lines_reg);
`ifdef SCORE_LEVEL_EN
    prod = PROD_W'(base) * PROD_W'(level_reg + LEVEL_W'(1));
    pts  = (32'(prod) > 32'(SCORE_MAX)) ? SUM_W'(SCORE_MAX) : SUM_W'(prod);
`else
    pts  = SUM_W'(base);
`endif
    // One extra bit so the overflow past SCORE_MAX is visible before clamping.
    sum       = SUM_W'(score_reg) + pts;
    add_score = (sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    conv_start = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE:       if (bus.clear_valid && bus.clear_ready) state_next = ADD;
      ADD: begin
        conv_start = 1'b1;
        state_next = CONV;
      end
      CONV:       if (conv_done) state_next = WAIT_FRAME;
      WAIT_FRAME: if (bus.frame_start) begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_all) begin
      state_reg  <= IDLE;
      lines_reg  <= '0;
      score_reg  <= '0;
      digits_reg <= '0;
      upd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      upd_reg   <= commit;
      if (state_reg == IDLE && bus.clear_valid) lines_reg <= bus.lines_cleared;
      if (state_reg == ADD) score_reg <= add_score;
      if (commit) digits_reg <= conv_bcd;
    end
  end

  // Converter is fed the freshly computed score so it starts in the same edge the score register loads.
  bin2bcd_seq #(
      .BIN_W  (SCORE_W),
      .DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
      .clk   (clk),
      .srst  (clear_all),
      .start (conv_start),
      .bin   (add_score),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
  );

  assign bus.clear_ready = (state_reg == IDLE) && !conv_busy;
  assign bus.score       = score_reg;
  assign bus.digit_hund  = digits_reg[11:8];
  assign bus.digit_tens  = digits_reg[7:4];
  assign bus.digit_ones  = digits_reg[3:0];
  assign bus.digits_upd  = upd_reg;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer; also meaningful with SCORE_LEVEL_EN defined.
module tb_score_sequencer;
  import score_pkg::*;

  localparam int SW   = 10;
  localparam int LW   = 4;
  localparam int SMAX = 999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_reset = 1'b0;

  score_sequencer_if #(.SCORE_W(SW), .LEVEL_W(LW)) bus ();

  score_sequencer #(.SCORE_W(SW), .SCORE_MAX(SMAX), .LEVEL_W(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .game_reset (game_reset),
      .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: score, level, total rows, value currently on display.
  int m_score = 0;
  int m_level = 0;
  int m_total = 0;
  int m_shown = 0;

  typedef struct {
    int lines;
    int exp_score;
    int exp_score_lvl;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int bcd_of(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int shown();
    return int'({bus.digit_hund, bus.digit_tens, bus.digit_ones});
  endfunction

  task automatic model_reset();
    m_score = 0; m_level = 0; m_total = 0; m_shown = 0;
  endtask

  task automatic model_event(input int lines);
    int base, p;
    case (lines)
      1: base = 1;
      2: base = 3;
      3: base = 5;
      4: base = 8;
      default: base = 0;
    endcase
    p = base;
`ifdef SCORE_LEVEL_EN
    p = base * (m_level + 1);
    if (p > SMAX) p = SMAX;
    if (lines >= 1 && lines <= 4) m_total += lines;
    m_level = (m_total / 10 > 9) ? 9 : m_total / 10;
`endif
    m_score = (m_score + p > SMAX) ? SMAX : m_score + p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: frame_start held high; 1: random frame pulses; 2: frames only during conversion, then one late frame.
  task automatic run_event(input int lines, input int mode);
    int t;
    int old_score;
    bit committed, fs, commit_now;
    chk("ready_idle", int'(bus.clear_ready), 1);
    old_score = m_score;
    bus.clear_valid   = 1'b1;
    bus.lines_cleared = 3'(lines);
    bus.frame_start   = (mode == 0);
    step();
    bus.clear_valid = 1'b0;
    model_event(lines);
    chk("ready_busy", int'(bus.clear_ready), 0);
    chk("score_before_add", int'(bus.score), old_score);
    t = 1;
    committed = 1'b0;
    while (!committed && t < 300) begin
      case (mode)
        0:       fs = 1'b1;
        1:       fs = ($urandom_range(3) == 0);
        default: fs = (t >= 2 && t <= 11) || (t == 40);
      endcase
      bus.frame_start = fs;
      commit_now = fs && (t >= 12);
      step();
      t++;
      if (commit_now) begin
        committed = 1'b1;
        m_shown = m_score;
      end
      if (t == 2) begin
        chk("score_add", int'(bus.score), m_score);
        chk("level", int'(bus.level), m_level);
      end
      chk("digits", shown(), bcd_of(m_shown));
      chk("digits_upd", int'(bus.digits_upd), int'(commit_now));
    end
    if (!committed) begin
      n_checks++;
      $display("FAIL commit_timeout: got no commit expected commit within 300 cycles");
    end
    bus.frame_start = 1'b0;
    step();
    chk("upd_clear", int'(bus.digits_upd), 0);
    chk("ready_back", int'(bus.clear_ready), 1);
    $display("event lines=%0d mode=%0d score=%0d level=%0d digits=%0h",
             lines, mode, bus.score, bus.level, shown());
  endtask

  task automatic pulse_game_reset();
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vecs[0] = '{4, 8, 8};
    vecs[1] = '{1, 9, 9};
    vecs[2] = '{2, 12, 12};
    vecs[3] = '{3, 17, 17};
    vecs[4] = '{0, 17, 17};
    vecs[5] = '{5, 17, 17};
    vecs[6] = '{7, 17, 17};
    vecs[7] = '{4, 25, 33};

    bus.clear_valid   = 1'b0;
    bus.lines_cleared = 3'd0;
    bus.frame_start   = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_score", int'(bus.score), 0);
    chk("rst_digits", shown(), 0);
    chk("rst_ready", int'(bus.clear_ready), 1);
    chk("rst_upd", int'(bus.digits_upd), 0);
    chk("rst_level", int'(bus.level), 0);
    rst = 1'b0;
    step();

    // Table: fixed event sequence with frame_start held high
    for (int i = 0; i < 8; i++) begin
      run_event(vecs[i].lines, 0);
`ifdef SCORE_LEVEL_EN
      chk("tbl_score", int'(bus.score), vecs[i].exp_score_lvl);
`else
      chk("tbl_score", int'(bus.score), vecs[i].exp_score);
`endif
      chk("tbl_digits", shown(), bcd_of(int'(bus.score)));
    end

    // Frame pulses during conversion must not commit
    pulse_game_reset();
    chk("gr_score", int'(bus.score), 0);
    chk("gr_digits", shown(), 0);
    run_event(2, 0);
    chk("pre_conv_digits", shown(), bcd_of(3));
    run_event(2, 2);
    chk("late_frame_score", int'(bus.score), 6);
    chk("late_frame_digits", shown(), bcd_of(6));

    // game_reset in the middle of a conversion
    run_event(3, 0);
    bus.clear_valid   = 1'b1;
    bus.lines_cleared = 3'd3;
    bus.frame_start   = 1'b1;
    step();
    bus.clear_valid = 1'b0;
    repeat (4) step();
    pulse_game_reset();
    chk("midconv_score", int'(bus.score), 0);
    chk("midconv_digits", shown(), 0);
    chk("midconv_ready", int'(bus.clear_ready), 1);
    chk("midconv_upd", int'(bus.digits_upd), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("midconv_no_upd", int'(bus.digits_upd), 0);
      chk("midconv_hold", shown(), 0);
    end
    bus.frame_start = 1'b0;
    $display("event game_reset mid-conversion score=%0d", bus.score);

    // game_reset wins over a simultaneous event
    run_event(4, 0);
    bus.clear_valid   = 1'b1;
    bus.lines_cleared = 3'd4;
    bus.frame_start   = 1'b1;
    game_reset        = 1'b1;
    step();
    game_reset      = 1'b0;
    bus.clear_valid = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    chk("override_score", int'(bus.score), 0);
    chk("override_ready", int'(bus.clear_ready), 1);
    step();
    chk("override_no_add", int'(bus.score), 0);
    chk("override_digits", shown(), 0);
    $display("event game_reset with simultaneous event score=%0d", bus.score);

    // Random events and frame timing against the model
    for (int i = 0; i < 40; i++) begin
      run_event(int'($urandom_range(7)), 1);
    end

    // Saturation at SCORE_MAX
    guard = 0;
    while (m_score < SMAX && guard < 200) begin
      run_event(4, 0);
      guard++;
    end
    chk("sat_score", int'(bus.score), 999);
    chk("sat_digits", shown(), 'h999);
    run_event(4, 0);
    chk("sat_hold_score", int'(bus.score), 999);
    chk("sat_hold_digits", shown(), 'h999);

`ifdef SCORE_LEVEL_EN
    pulse_game_reset();
    for (int i = 0; i < 10; i++) run_event(1, 0);
    chk("lvl_after_10", int'(bus.level), 1);
    chk("lvl_score_10", int'(bus.score), 10);
    run_event(4, 0);
    chk("lvl_score_x2", int'(bus.score), 26);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
